// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus the UART transmit/receive byte streams served by mem_io_responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        prog_stop;

  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready, rx_valid, rx_data,
    output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, prog_stop
  );

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready, rx_valid, rx_data,
    input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, prog_stop
  );
endinterface

// File: rtl/mem_io_responder.sv
// CPU-facing responder: byte RAM, UART TX/RX FIFOs, cycle counter with coherent
// snapshot, and a sticky program-stop flag behind a 1-cycle read latency.
module mem_io_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  input logic               rdy_in,
  mem_io_responder_if.slave bus
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_NEAR_FULL = (TX_AW + 1)'(TX_DEPTH - 2);

  logic                  is_io;
  logic                  io_uart;
  logic                  io_ctrl;
  logic                  io_snap1;
  logic                  io_snap2;
  logic                  io_snap3;
  logic                  ram_we;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  unused_addr;

  always_comb begin
    is_io    = (bus.mem_a[17:16] == 2'b11);
    io_uart  = is_io && (bus.mem_a[15:0] == 16'h0000);
    io_ctrl  = is_io && (bus.mem_a[15:0] == 16'h0004);
    io_snap1 = is_io && (bus.mem_a[15:0] == 16'h0005);
    io_snap2 = is_io && (bus.mem_a[15:0] == 16'h0006);
    io_snap3 = is_io && (bus.mem_a[15:0] == 16'h0007);
    ram_we   = !is_io && bus.mem_wr;
    ram_addr = bus.mem_a[RAM_ADDR_W-1:0];
  end

  assign unused_addr = ^bus.mem_a[31:18];

  // RAM: plain synchronous read port so a read right after a write sees the new byte
  logic [7:0] ram [2**RAM_ADDR_W];
  logic [7:0] ram_rd_q;

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram[ram_addr] <= bus.mem_dout;
    end
    ram_rd_q <= ram[ram_addr];
  end

  // TX FIFO
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wptr_q, tx_wptr_d;
  logic [TX_AW:0] tx_rptr_q, tx_rptr_d;
  logic [TX_AW:0] tx_level_d;
  logic           tx_empty;
  logic           tx_full;
  logic           tx_pop;
  logic           tx_push;
  logic           io_buffer_full_q, io_buffer_full_d;

  always_comb begin
    tx_empty = (tx_wptr_q == tx_rptr_q);
    tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
               (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
    tx_pop   = !tx_empty && bus.tx_ready;
    // a pop in the same cycle frees the slot, so a push to a full FIFO still lands
    tx_push  = io_uart && bus.mem_wr && (bus.mem_dout != 8'h00) && (!tx_full || tx_pop);
    tx_wptr_d = tx_wptr_q + (TX_AW + 1)'(tx_push);
    tx_rptr_d = tx_rptr_q + (TX_AW + 1)'(tx_pop);
    tx_level_d = tx_wptr_d - tx_rptr_d;
    io_buffer_full_d = (tx_level_d >= TX_NEAR_FULL);
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) begin
      tx_mem[tx_wptr_q[TX_AW-1:0]] <= bus.mem_dout;
    end
  end

  // RX FIFO
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wptr_q, rx_wptr_d;
  logic [RX_AW:0] rx_rptr_q, rx_rptr_d;
  logic           rx_empty;
  logic           rx_full;
  logic           rx_accept;
  logic           rx_pop;

  always_comb begin
    rx_empty  = (rx_wptr_q == rx_rptr_q);
    rx_full   = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);
    rx_accept = bus.rx_valid && !rx_full;
    rx_pop    = io_uart && !bus.mem_wr && !rx_empty;
    rx_wptr_d = rx_wptr_q + (RX_AW + 1)'(rx_accept);
    rx_rptr_d = rx_rptr_q + (RX_AW + 1)'(rx_pop);
  end

  always_ff @(posedge clk_in) begin
    if (rx_accept) begin
      rx_mem[rx_wptr_q[RX_AW-1:0]] <= bus.rx_data;
    end
  end

  // Counter, snapshot, stop flag and the registered read-data select
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        prog_stop_q, prog_stop_d;
  logic        sel_ram_q, sel_ram_d;
  logic [7:0]  io_rd_q, io_rd_d;

  always_comb begin
    cnt_d       = rdy_in ? (cnt_q + 32'd1) : cnt_q;
    snap_d      = snap_q;
    prog_stop_d = prog_stop_q || (io_ctrl && bus.mem_wr);
    sel_ram_d   = !is_io && !bus.mem_wr;
    io_rd_d     = 8'h00;
    if (!bus.mem_wr) begin
      if (io_uart) begin
        io_rd_d = rx_empty ? 8'h00 : rx_mem[rx_rptr_q[RX_AW-1:0]];
      end else if (io_ctrl) begin
        snap_d  = cnt_q;
        io_rd_d = cnt_q[7:0];
      end else if (io_snap1) begin
        io_rd_d = snap_q[15:8];
      end else if (io_snap2) begin
        io_rd_d = snap_q[23:16];
      end else if (io_snap3) begin
        io_rd_d = snap_q[31:24];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wptr_q        <= '0;
      tx_rptr_q        <= '0;
      rx_wptr_q        <= '0;
      rx_rptr_q        <= '0;
      io_buffer_full_q <= 1'b0;
      cnt_q            <= '0;
      snap_q           <= '0;
      prog_stop_q      <= 1'b0;
      sel_ram_q        <= 1'b0;
      io_rd_q          <= 8'h00;
    end else begin
      tx_wptr_q        <= tx_wptr_d;
      tx_rptr_q        <= tx_rptr_d;
      rx_wptr_q        <= rx_wptr_d;
      rx_rptr_q        <= rx_rptr_d;
      io_buffer_full_q <= io_buffer_full_d;
      cnt_q            <= cnt_d;
      snap_q           <= snap_d;
      prog_stop_q      <= prog_stop_d;
      sel_ram_q        <= sel_ram_d;
      io_rd_q          <= io_rd_d;
    end
  end

  assign bus.mem_din        = sel_ram_q ? ram_rd_q : io_rd_q;
  assign bus.io_buffer_full = io_buffer_full_q;
  assign bus.tx_valid       = !tx_empty;
  assign bus.tx_data        = tx_mem[tx_rptr_q[TX_AW-1:0]];
  assign bus.rx_ready       = !rx_full;
  assign bus.prog_stop      = prog_stop_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus randomized traffic against
// a queue/associative-array reference model of the memory map.
module tb_mem_io_responder;
  localparam int TXD = 8;
  localparam int RXD = 4;
  localparam logic [31:0] IDLE_A = 32'h0000_0100;
  localparam logic [31:0] A_UART = 32'h0003_0000;
  localparam logic [31:0] A_CTRL = 32'h0003_0004;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  mem_io_responder_if bus ();

  mem_io_responder #(
    .RAM_ADDR_W(17),
    .TX_DEPTH  (TXD),
    .RX_DEPTH  (RXD)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus   (bus)
  );

  int n_total;
  int n_bad;

  logic [7:0]  m_ram [int];
  logic [7:0]  m_tx [$];
  logic [7:0]  m_rx [$];
  logic [7:0]  tx_seen [$];
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  logic        m_stop;
  logic        m_full;
  logic [7:0]  m_din;
  logic        m_din_known;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently on the bus.
  task automatic model_step();
    logic [31:0] a;
    logic        io;
    logic [15:0] off;
    int          k;
    bit          tx_pop;
    bit          tx_acc;
    bit          rx_acc;
    a = bus.mem_a;
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_cnt = '0;
      m_snap = '0;
      m_stop = 1'b0;
      m_full = 1'b0;
      m_din = 8'h00;
      m_din_known = 1'b1;
      return;
    end
    io  = (a[17:16] == 2'b11);
    off = a[15:0];
    k   = int'(a[16:0]);
    tx_pop = (m_tx.size() > 0) && bus.tx_ready;
    rx_acc = bus.rx_valid && (m_rx.size() < RXD);
    tx_acc = 1'b0;
    m_din = 8'h00;
    m_din_known = 1'b1;
    if (bus.mem_wr) begin
      if (!io) m_ram[k] = bus.mem_dout;
      else if (off == 16'h0000) tx_acc = (bus.mem_dout != 8'h00) && ((m_tx.size() < TXD) || tx_pop);
      else if (off == 16'h0004) m_stop = 1'b1;
    end else begin
      if (!io) begin
        if (m_ram.exists(k)) m_din = m_ram[k];
        else m_din_known = 1'b0;
      end else if (off == 16'h0000) begin
        if (m_rx.size() > 0) m_din = m_rx.pop_front();
      end else if (off == 16'h0004) begin
        m_din = m_cnt[7:0];
        m_snap = m_cnt;
      end else if (off == 16'h0005) m_din = m_snap[15:8];
      else if (off == 16'h0006) m_din = m_snap[23:16];
      else if (off == 16'h0007) m_din = m_snap[31:24];
    end
    if (tx_pop) void'(m_tx.pop_front());
    if (tx_acc) m_tx.push_back(bus.mem_dout);
    if (rx_acc) m_rx.push_back(bus.rx_data);
    if (rdy) m_cnt = m_cnt + 32'd1;
    m_full = (m_tx.size() >= TXD - 2);
  endtask

  task automatic compare();
    if (m_din_known) check_val("mem_din", bus.mem_din, m_din);
    check_val("io_buffer_full", bus.io_buffer_full, m_full);
    check_val("prog_stop", bus.prog_stop, m_stop);
    check_val("tx_valid", bus.tx_valid, m_tx.size() > 0);
    if (m_tx.size() > 0) check_val("tx_data", bus.tx_data, m_tx[0]);
    check_val("rx_ready", bus.rx_ready, m_rx.size() < RXD);
  endtask

  task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
    @(negedge clk);
    bus.mem_a = a;
    bus.mem_wr = wr;
    bus.mem_dout = d;
    if (!rst && bus.tx_valid && bus.tx_ready) tx_seen.push_back(bus.tx_data);
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    logic [7:0]  exp37 [2];
    logic [31:0] a;
    logic        wr;
    int          sel;
    n_total = 0;
    n_bad = 0;
    exp37[0] = 8'h41;
    exp37[1] = 8'h42;
    rst = 1'b1;
    rdy = 1'b1;
    bus.mem_a = IDLE_A;
    bus.mem_wr = 1'b0;
    bus.mem_dout = 8'h00;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    m_cnt = '0; m_snap = '0; m_stop = 1'b0; m_full = 1'b0; m_din = 8'h00; m_din_known = 1'b0;

    cyc(IDLE_A, 1'b0, 8'h00);
    cyc(IDLE_A, 1'b0, 8'h00);
    check_val("rst_mem_din", bus.mem_din, 8'h00);
    check_val("rst_tx_valid", bus.tx_valid, 1'b0);
    check_val("rst_rx_ready", bus.rx_ready, 1'b1);
    check_val("rst_full", bus.io_buffer_full, 1'b0);
    check_val("rst_stop", bus.prog_stop, 1'b0);
    rst = 1'b0;

    // RAM write then read, and write-then-read on the very next cycle
    cyc(32'h0000_1234, 1'b1, 8'hA5);
    check_val("wr_cycle_din", bus.mem_din, 8'h00);
    cyc(32'h0000_1234, 1'b0, 8'h00);
    check_val("ram_rd_a5", bus.mem_din, 8'hA5);
    cyc(32'h0000_1235, 1'b1, 8'h3C);
    cyc(32'h0000_1235, 1'b0, 8'h00);
    check_val("ram_rd_3c", bus.mem_din, 8'h3C);

    // TX: zero bytes are not queued
    bus.tx_ready = 1'b1;
    tx_seen.delete();
    cyc(A_UART, 1'b1, 8'h41);
    cyc(A_UART, 1'b1, 8'h00);
    cyc(A_UART, 1'b1, 8'h42);
    repeat (4) cyc(IDLE_A, 1'b0, 8'h00);
    check_val("tx_seq_len", tx_seen.size(), 2);
    for (int i = 0; i < 2; i++)
      check_val("tx_seq", (i < tx_seen.size()) ? {24'h0, tx_seen[i]} : 32'hFFFF_FFFF, exp37[i]);

    // TX fill with the sink stalled, then drain
    bus.tx_ready = 1'b0;
    tx_seen.delete();
    for (int i = 0; i < 10; i++) begin
      cyc(A_UART, 1'b1, 8'h10 + 8'(i));
      if (i == 4) check_val("full_after5", bus.io_buffer_full, 1'b0);
      if (i == 5) check_val("full_after6", bus.io_buffer_full, 1'b1);
    end
    check_val("tx_full_valid", bus.tx_valid, 1'b1);
    bus.tx_ready = 1'b1;
    repeat (11) cyc(IDLE_A, 1'b0, 8'h00);
    check_val("drain_len", tx_seen.size(), 8);
    for (int i = 0; i < 8; i++)
      check_val("drain_byte", (i < tx_seen.size()) ? {24'h0, tx_seen[i]} : 32'hFFFF_FFFF, 32'h10 + 32'(i));
    check_val("drain_full_clr", bus.io_buffer_full, 1'b0);

    // RX: empty read, single byte, and overflow back-pressure
    cyc(A_UART, 1'b0, 8'h00);
    check_val("rx_empty_rd", bus.mem_din, 8'h00);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h7E;
    cyc(IDLE_A, 1'b0, 8'h00);
    bus.rx_valid = 1'b0;
    cyc(A_UART, 1'b0, 8'h00);
    check_val("rx_rd_7e", bus.mem_din, 8'h7E);
    cyc(A_UART, 1'b0, 8'h00);
    check_val("rx_after_pop", bus.mem_din, 8'h00);
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rx_data = 8'hC0 + 8'(i);
      cyc(IDLE_A, 1'b0, 8'h00);
    end
    bus.rx_valid = 1'b0;
    check_val("rx_full_ready", bus.rx_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(A_UART, 1'b0, 8'h00);
      check_val("rx_fifo_byte", bus.mem_din, 8'hC0 + 8'(i));
    end

    // Counter snapshot coherence and rdy_in gating
    rst = 1'b1;
    cyc(IDLE_A, 1'b0, 8'h00);
    rst = 1'b0;
    repeat (255) cyc(IDLE_A, 1'b0, 8'h00);
    cyc(A_CTRL, 1'b0, 8'h00);
    check_val("cnt_b0", bus.mem_din, 8'hFF);
    cyc(A_CTRL + 32'd1, 1'b0, 8'h00);
    check_val("cnt_b1", bus.mem_din, 8'h00);
    cyc(A_CTRL + 32'd2, 1'b0, 8'h00);
    check_val("cnt_b2", bus.mem_din, 8'h00);
    cyc(A_CTRL + 32'd3, 1'b0, 8'h00);
    check_val("cnt_b3", bus.mem_din, 8'h00);
    rdy = 1'b0;
    repeat (10) cyc(IDLE_A, 1'b0, 8'h00);
    cyc(A_CTRL, 1'b0, 8'h00);
    check_val("cnt_gated", bus.mem_din, 8'h03);
    cyc(A_CTRL + 32'd1, 1'b0, 8'h00);
    check_val("cnt_gated_b1", bus.mem_din, 8'h01);
    rdy = 1'b1;
    cyc(32'h0003_0008, 1'b0, 8'h00);
    check_val("unmapped_rd", bus.mem_din, 8'h00);

    // Stop flag, then reset with TX and RX bytes pending
    cyc(A_CTRL, 1'b1, 8'h00);
    check_val("stop_set", bus.prog_stop, 1'b1);
    bus.tx_ready = 1'b0;
    cyc(A_UART, 1'b1, 8'h55);
    cyc(A_UART, 1'b1, 8'h66);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h99;
    cyc(A_UART, 1'b0, 8'h00);
    bus.rx_valid = 1'b0;
    cyc(IDLE_A, 1'b0, 8'h00);
    check_val("stop_held", bus.prog_stop, 1'b1);
    rst = 1'b1;
    cyc(A_CTRL, 1'b0, 8'h00);
    rst = 1'b0;
    check_val("mid_rst_stop", bus.prog_stop, 1'b0);
    check_val("mid_rst_tx_valid", bus.tx_valid, 1'b0);
    check_val("mid_rst_din", bus.mem_din, 8'h00);
    cyc(A_UART, 1'b0, 8'h00);
    check_val("mid_rst_rx_gone", bus.mem_din, 8'h00);
    cyc(32'h0000_1234, 1'b0, 8'h00);
    check_val("ram_survives_rst", bus.mem_din, 8'hA5);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      bus.tx_ready = (i < 1500) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      bus.rx_valid = ($urandom_range(0, 2) == 0);
      bus.rx_data = 8'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    a = 32'h0000_0000 + 32'($urandom_range(0, 15));
        2:       a = 32'h0001_0000 + 32'($urandom_range(0, 15));
        3:       a = 32'h0002_0000 + 32'($urandom_range(0, 15));
        4, 5:    a = A_UART;
        6:       a = A_CTRL + 32'($urandom_range(0, 3));
        7:       a = A_CTRL;
        8:       a = ($urandom_range(0, 1) == 1) ? 32'h0003_0008 : 32'h0003_FFFF;
        default: a = {14'($urandom), 2'b11, 16'h0000};
      endcase
      wr = rst ? 1'b0 : ($urandom_range(0, 2) == 0);
      if (a == A_CTRL && $urandom_range(0, 7) != 0) wr = 1'b0;
      cyc(a, wr, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_ADDR_W, 17, RAM byte-address width (128 KB).
REQ-002 Parameter TX_DEPTH, 8, TX FIFO entries (power of 2).
REQ-003 Parameter RX_DEPTH, 4, RX FIFO entries (power of 2).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk_in, input, 1, the system clock; all state updates on its rising edge.
REQ-006 Port rst_in, input, 1, synchronous active-high reset.
REQ-007 Port rdy_in, input, 1, CPU-run qualifier; gates the cycle counter only.
REQ-008 Port mem_a, input, 32, CPU byte address; only [17:0] decoded.
REQ-009 Port mem_dout, input, 8, CPU write data.
REQ-010 Port mem_wr, input, 1, 1 = write, 0 = read.
REQ-011 Port mem_din, output, 8, read data returned to the CPU.
REQ-012 Port io_buffer_full, output, 1, TX FIFO near-full indication to the CPU.
REQ-013 Port tx_valid / tx_data / tx_ready, output / output / input, 1 / 8 / 1, byte stream to the UART transmitter.
REQ-014 Port rx_valid / rx_data / rx_ready, input / input / output, 1 / 8 / 1, byte stream from the UART receiver.
REQ-015 Port prog_stop, output, 1, sticky program-stop flag.

Function
REQ-016 Decode: mem_a[17:16]==2'b11 SHALL select IO; any other value SHALL select RAM at mem_a[16:0].
REQ-017 RAM write (mem_wr=1): byte stored at the next rising edge.
REQ-018 RAM read (mem_wr=0): mem_din SHALL carry the addressed byte exactly 1 cycle after the address is presented; a read issued in the cycle after a write to the same address SHALL return the new byte.
REQ-019 After a write cycle, mem_din SHALL be 8'h00 in the following cycle.
REQ-020 IO write 0x30000: data != 8'h00 SHALL be pushed into the TX FIFO; 8'h00 SHALL be ignored.
REQ-021 IO write 0x30004: prog_stop SHALL set on the next edge and stay set until reset.
REQ-022 IO read 0x30000: mem_din SHALL carry the RX FIFO head 1 cycle later, and the head SHALL be popped; if the RX FIFO is empty, mem_din SHALL be 8'h00 and no pop SHALL occur.
REQ-023 Cycle counter: 32-bit, SHALL increment by 1 on each edge with rdy_in=1, and SHALL wrap from FFFFFFFF to 0.
REQ-024 IO read 0x30004 (byte 0): the counter value SHALL be latched into a snapshot register, and counter[7:0] returned 1 cycle later.
REQ-025 IO reads 0x30005/0x30006/0x30007 SHALL return snapshot bytes 1/2/3, so a 4-byte read is coherent.
REQ-026 IO accesses to other addresses: reads SHALL return 8'h00; writes SHALL be ignored.
REQ-027 TX FIFO: tx_valid = not empty; tx_data = head; a pop SHALL occur on an edge with tx_valid and tx_ready both high.
REQ-028 io_buffer_full SHALL be registered and SHALL be 1 when the TX occupancy is >= TX_DEPTH-2, covering the CPU's 1-cycle reaction lag.
REQ-029 A push to a full TX FIFO SHALL be dropped; the FIFO contents SHALL be unchanged.
REQ-030 A simultaneous TX push and pop SHALL leave the occupancy unchanged, including when the FIFO is full: the pop frees a slot and the push is accepted.
REQ-031 RX FIFO: rx_ready = not full; a byte SHALL be accepted on an edge with rx_valid and rx_ready both high; a simultaneous accept and CPU pop SHALL be allowed.
REQ-032 FIFO pointers: log2(DEPTH) bits plus a wrap bit; full/empty SHALL be derived from the pointer comparison.

Reset
REQ-033 On rst_in=1, the following SHALL clear to 0 at the edge: mem_din, io_buffer_full, prog_stop, the counter, the snapshot, and all FIFO pointers; tx_valid=0 and rx_ready=1 after reset.
REQ-034 RAM contents SHALL NOT be cleared by reset.
REQ-035 A reset mid-operation SHALL discard pending TX/RX bytes and any in-flight read result; mem_din SHALL be 0 in the cycle after reset.

Verification
REQ-036 Write 8'hA5 to 0x01234, then read 0x01234 -> mem_din=8'hA5 exactly 1 cycle after the read address.
REQ-037 Write 8'h41, 8'h00, 8'h42 to 0x30000 with tx_ready=1 -> tx_data sequence is 41, 42 only.
REQ-038 tx_ready=0, 6 pushes to 0x30000 -> io_buffer_full=1 after the 6th push; pushes 9 and 10 dropped; draining yields the first 8 bytes in order.
REQ-039 Counter at 0x000000FF; read 0x30004..0x30007 on consecutive cycles -> bytes FF,00,00,00 (snapshot held while the counter advances).
REQ-040 RX FIFO empty, read 0x30000 -> 8'h00; then inject 8'h7E via rx_valid and read again -> 8'h7E, and the FIFO is empty afterwards.
REQ-041 Write to 0x30004, then assert rst_in mid-TX -> prog_stop 1 then 0; tx_valid=0; a byte written to RAM before reset reads back unchanged.
